// File: rtl/lp_printer.sv
// LP20 line-printer responder: decodes characters and paper-motion commands,
// keeps the DAVFU and line counter, and streams printable bytes to a console sink.
module lp_printer #(
    parameter int DEFLEN = 66,
    parameter int MAXLEN = 143
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] lpDATA,
    input  logic       lpPI,
    input  logic       lpSTROBE,
    output logic       lpDEMAND,
    output logic       lpVFURDY,
    output logic       lpVFUERR,
    output logic       lpTOF,
    output logic [7:0] outDATA,
    output logic       outVALID,
    input  logic       outREADY
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_CHAR, ST_SLEW, ST_SKIP, ST_LDLO, ST_LDHI
    } state_t;

    localparam logic [7:0] LEN_DEF   = 8'(DEFLEN);
    localparam logic [7:0] LEN_MAX   = 8'(MAXLEN);
    localparam logic [7:0] CODE_STOP = 8'h6F;

    state_t      r_state;
    logic [7:0]  r_line;
    logic [7:0]  r_len;
    logic [7:0]  r_idx;
    logic [3:0]  r_cnt;
    logic [3:0]  r_chan;
    logic [5:0]  r_lo;
    logic        r_demand;
    logic        r_vfurdy;
    logic        r_vfuerr;
    logic        r_tof;
    logic [7:0]  r_out_data;
    logic        r_out_valid;
    logic [11:0] r_vfu [MAXLEN];

    logic        w_strobe;
    logic        w_xfer;
    logic [7:0]  w_line_nxt;
    logic [11:0] w_vfu_word;
    logic        w_hit;
    logic        w_vfu_we;

    // Byte that accompanies advancing paper from the given line: FF on wrap to top of form.
    function automatic logic [7:0] motion_byte(input logic [7:0] line, input logic [7:0] len);
        return (line >= len - 8'd1) ? 8'h0C : 8'h0A;
    endfunction

    assign w_strobe   = lpSTROBE & r_demand;
    assign w_xfer     = r_out_valid & outREADY;
    assign w_line_nxt = (r_line >= r_len - 8'd1) ? 8'd0 : r_line + 8'd1;
    assign w_vfu_word = r_vfu[w_line_nxt];
    assign w_hit      = w_vfu_word[r_chan];
    assign w_vfu_we   = (r_state == ST_LDHI) & w_strobe & (lpDATA != CODE_STOP);

    assign lpDEMAND = r_demand;
    assign lpVFURDY = r_vfurdy;
    assign lpVFUERR = r_vfuerr;
    assign lpTOF    = r_tof;
    assign outDATA  = r_out_data;
    assign outVALID = r_out_valid;

    // DAVFU storage: a full 12-channel line is written once its high half arrives.
    always_ff @(posedge clk) begin
        if (w_vfu_we) begin
            r_vfu[r_idx] <= {lpDATA[5:0], r_lo};
        end
    end

    // Control FSM with registered handshake, VFU status and paper-position outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_line      <= 8'd0;
            r_len       <= LEN_DEF;
            r_idx       <= 8'd0;
            r_cnt       <= 4'd0;
            r_chan      <= 4'd0;
            r_lo        <= 6'd0;
            r_demand    <= 1'b0;
            r_vfurdy    <= 1'b0;
            r_vfuerr    <= 1'b0;
            r_tof       <= 1'b1;
            r_out_data  <= 8'd0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_demand <= 1'b1;
                    if (w_strobe) begin
                        if (!lpPI && (lpDATA == 8'hEC || lpDATA == 8'hEE)) begin
                            r_state  <= ST_LDLO;
                            r_idx    <= 8'd0;
                            r_vfurdy <= 1'b0;
                        end else if (!lpPI) begin
                            r_state     <= ST_CHAR;
                            r_out_data  <= lpDATA;
                            r_out_valid <= 1'b1;
                            r_demand    <= 1'b0;
                        end else if (!lpDATA[4]) begin
                            r_demand <= 1'b0;
                            if (lpDATA[3:0] != 4'd0) begin
                                r_state     <= ST_SLEW;
                                r_cnt       <= lpDATA[3:0];
                                r_out_data  <= motion_byte(r_line, r_len);
                                r_out_valid <= 1'b1;
                            end
                        end else begin
                            r_demand <= 1'b0;
                            // Channels 13-16 do not exist; skipping needs a loaded VFU.
                            if (lpDATA[3:0] >= 4'd12 || !r_vfurdy) begin
                                r_vfuerr <= 1'b1;
                            end else begin
                                r_state     <= ST_SKIP;
                                r_chan      <= lpDATA[3:0];
                                r_idx       <= 8'd0;
                                r_out_data  <= motion_byte(r_line, r_len);
                                r_out_valid <= 1'b1;
                            end
                        end
                    end
                end
                ST_CHAR: begin
                    if (w_xfer) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                        r_demand    <= 1'b1;
                    end
                end
                ST_SLEW: begin
                    if (w_xfer) begin
                        r_line <= w_line_nxt;
                        r_tof  <= (w_line_nxt == 8'd0);
                        r_cnt  <= r_cnt - 4'd1;
                        if (r_cnt == 4'd1) begin
                            r_state     <= ST_IDLE;
                            r_out_valid <= 1'b0;
                            r_demand    <= 1'b1;
                        end else begin
                            r_out_data <= motion_byte(w_line_nxt, r_len);
                        end
                    end
                end
                ST_SKIP: begin
                    if (w_xfer) begin
                        r_line <= w_line_nxt;
                        r_tof  <= (w_line_nxt == 8'd0);
                        r_idx  <= r_idx + 8'd1;
                        // A full form without a hit lands back on the start line, which never matches.
                        if (r_idx + 8'd1 == r_len) begin
                            r_vfuerr    <= 1'b1;
                            r_state     <= ST_IDLE;
                            r_out_valid <= 1'b0;
                            r_demand    <= 1'b1;
                        end else if (w_hit) begin
                            r_state     <= ST_IDLE;
                            r_out_valid <= 1'b0;
                            r_demand    <= 1'b1;
                        end else begin
                            r_out_data <= motion_byte(w_line_nxt, r_len);
                        end
                    end
                end
                ST_LDLO: begin
                    if (w_strobe) begin
                        if (lpDATA == CODE_STOP) begin
                            r_state <= ST_IDLE;
                            if (r_idx == 8'd0) begin
                                r_len    <= LEN_DEF;
                                r_vfuerr <= 1'b1;
                            end else begin
                                r_len    <= r_idx;
                                r_line   <= 8'd0;
                                r_tof    <= 1'b1;
                                r_vfurdy <= 1'b1;
                                r_vfuerr <= 1'b0;
                            end
                        end else begin
                            r_lo    <= lpDATA[5:0];
                            r_state <= ST_LDHI;
                        end
                    end
                end
                ST_LDHI: begin
                    if (w_strobe) begin
                        if (lpDATA == CODE_STOP || r_idx == LEN_MAX - 8'd1) begin
                            r_state  <= ST_IDLE;
                            r_len    <= LEN_DEF;
                            r_vfuerr <= 1'b1;
                        end else begin
                            r_idx   <= r_idx + 8'd1;
                            r_state <= ST_LDLO;
                        end
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
